// File: rtl/nn_pkg.sv
// Shared definitions for the fully-connected layer datapath: serializer state,
// counter sizing helper and the default neuron word width.
package nn_pkg;

  localparam int NN_DATA_WIDTH = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_t;

  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/layer_output_serializer.sv
// Captures all neuron outputs of a layer at once and streams them, neuron 0
// first, one word per cycle onto the next layer's shared input bus.
module layer_output_serializer
  import nn_pkg::*;
#(
  parameter int NUM_NEURONS = 30,
  parameter int DATA_WIDTH  = NN_DATA_WIDTH
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_NEURONS*DATA_WIDTH-1:0] in_data,
  input  logic [NUM_NEURONS-1:0]            in_valid,
  output logic [DATA_WIDTH-1:0]             out_data,
  output logic                              out_valid,
  output logic                              busy,
  output logic                              done,
  output logic                              overrun,
  output logic                              mismatch
);

  localparam int              CW        = cnt_width(NUM_NEURONS);
  localparam int              BUF_WORDS = (NUM_NEURONS > 1) ? NUM_NEURONS - 1 : 1;
  localparam int              BW        = BUF_WORDS * DATA_WIDTH;
  localparam logic [CW-1:0]   LAST      = CW'(NUM_NEURONS - 1);

  ser_state_t             state_q, state_d;
  logic [CW-1:0]          count_q, count_d;
  logic [BW-1:0]          buf_q, buf_d;
  logic [DATA_WIDTH-1:0]  head_q, head_d;
  logic [DATA_WIDTH-1:0]  out_data_q, out_data_d;
  logic                   out_valid_q, out_valid_d;
  logic                   done_q, done_d;
  logic                   overrun_q, overrun_d;
  logic                   mismatch_q, mismatch_d;

  logic                   cap;
  logic [DATA_WIDTH-1:0]  cap_w0;
  logic [BW-1:0]          cap_buf;

  assign cap     = &in_valid;
  assign cap_w0  = in_data[DATA_WIDTH-1:0];
  assign cap_buf = BW'(in_data >> DATA_WIDTH);

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    buf_d       = buf_q;
    head_d      = head_q;
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;
    done_d      = 1'b0;
    overrun_d   = overrun_q;
    mismatch_d  = mismatch_q | ((|in_valid) & ~cap);

    case (state_q)
      IDLE: begin
        if (cap) begin
          out_data_d  = cap_w0;
          out_valid_d = 1'b1;
          buf_d       = cap_buf;
          if (NUM_NEURONS == 1) begin
            done_d = 1'b1;
          end else begin
            state_d = SHIFT;
            count_d = CW'(1);
          end
        end
      end
      SHIFT: begin
        out_valid_d = 1'b1;
        // count 0 in SHIFT marks a back-to-back frame whose word 0 waits in head_q
        if (count_q == '0) begin
          out_data_d = head_q;
          count_d    = CW'(1);
          if (cap) overrun_d = 1'b1;
        end else begin
          out_data_d = buf_q[DATA_WIDTH-1:0];
          buf_d      = buf_q >> DATA_WIDTH;
          count_d    = count_q + CW'(1);
          if (count_q == LAST) begin
            done_d = 1'b1;
            if (cap) begin
              head_d  = cap_w0;
              buf_d   = cap_buf;
              count_d = '0;
            end else begin
              state_d = IDLE;
              count_d = '0;
            end
          end else if (cap) begin
            overrun_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      count_q     <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
      overrun_q   <= 1'b0;
      mismatch_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
      overrun_q   <= overrun_d;
      mismatch_q  <= mismatch_d;
    end
  end

  // Frame storage carries no control meaning, so it is left out of reset.
  always_ff @(posedge clk) begin
    buf_q  <= buf_d;
    head_q <= head_d;
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign busy      = (state_q == SHIFT) | out_valid_q;
  assign done      = done_q;
  assign overrun   = overrun_q;
  assign mismatch  = mismatch_q;

endmodule

// File: tb/tb_layer_output_serializer.sv
// Scoreboard bench: the driver predicts whole frames from capture rules, a
// negedge monitor pops and compares every word the serializer presents.
module tb_layer_output_serializer;

  localparam int N  = 4;
  localparam int DW = 16;

  typedef struct {
    logic [DW-1:0] d;
    bit            last;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [N*DW-1:0]   in_data = '0;
  logic [N-1:0]      in_valid = '0;
  logic [DW-1:0]     out_data;
  logic              out_valid, busy, done, overrun, mismatch;

  logic              rst1 = 1'b1;
  logic [DW-1:0]     in_data1 = '0;
  logic [0:0]        in_valid1 = '0;
  logic [DW-1:0]     out_data1;
  logic              out_valid1, busy1, done1, overrun1, mismatch1;

  layer_output_serializer #(.NUM_NEURONS(N), .DATA_WIDTH(DW)) u_dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .out_data(out_data), .out_valid(out_valid), .busy(busy), .done(done),
    .overrun(overrun), .mismatch(mismatch)
  );

  layer_output_serializer #(.NUM_NEURONS(1), .DATA_WIDTH(DW)) u_dut1 (
    .clk(clk), .rst(rst1), .in_data(in_data1), .in_valid(in_valid1),
    .out_data(out_data1), .out_valid(out_valid1), .busy(busy1), .done(done1),
    .overrun(overrun1), .mismatch(mismatch1)
  );

  always #5 clk = ~clk;

  int   n_chk = 0;
  int   n_fail = 0;
  exp_t sb[$];
  int   m_rem = 0;      // words of accepted frames not yet emitted
  bit   m_vld = 0, m_ov = 0, m_mm = 0;
  bit   mon_en = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Drives one cycle of inputs; model and scoreboard advance on the sampling edge.
  task automatic step(input logic r, input logic [N-1:0] v, input logic [N*DW-1:0] d);
    bit cap, acc, ev, ov, mm;
    int rem;
    rst = r; in_valid = v; in_data = d;
    cap = (v == '1);
    acc = 0; ev = 0; ov = m_ov; mm = m_mm; rem = m_rem;
    if (r) begin
      rem = 0; ov = 0; mm = 0;
    end else begin
      mm = mm | ((v != '0) && !cap);
      ev = (rem > 0) || cap;
      if (cap && rem <= 1) begin
        acc = 1;
        rem = (rem == 0) ? N - 1 : N;
      end else begin
        if (cap) ov = 1;
        rem = (rem > 0) ? rem - 1 : 0;
      end
    end
    @(posedge clk);
    if (r) sb.delete();
    if (acc)
      for (int i = 0; i < N; i++) sb.push_back('{d[i*DW +: DW], i == N - 1});
    m_rem = rem; m_vld = ev; m_ov = ov; m_mm = mm;
    #1;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      chk("out_valid", {31'b0, out_valid}, {31'b0, m_vld});
      chk("busy", {31'b0, busy}, {31'b0, m_vld});
      chk("overrun", {31'b0, overrun}, {31'b0, m_ov});
      chk("mismatch", {31'b0, mismatch}, {31'b0, m_mm});
      if (out_valid === 1'b1) begin
        if (sb.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL sb_empty: got valid word %0h expected none at %0t", out_data, $time);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("out_data", {16'b0, out_data}, {16'b0, e.d});
          chk("done", {31'b0, done}, {31'b0, e.last});
        end
      end else begin
        chk("done_idle", {31'b0, done}, 32'h0);
      end
    end
  end

  initial begin
    logic [N*DW-1:0] rd;
    step(1, '0, '0);
    step(1, '0, '0);
    mon_en = 1;
    chk("reset_out_data", {16'b0, out_data}, 32'h0);

    // basic frame
    step(0, 4'hF, {16'h0004, 16'h0003, 16'h0002, 16'h0001});
    repeat (5) step(0, '0, '0);

    // back-to-back frames, second capture on the last-word cycle
    step(0, 4'hF, {16'h0004, 16'h0003, 16'h0002, 16'h0001});
    step(0, '0, '0);
    step(0, '0, '0);
    step(0, 4'hF, {16'h00D0, 16'h00C0, 16'h00B0, 16'h00A0});
    repeat (6) step(0, '0, '0);

    // overrun
    step(0, 4'hF, {16'h1114, 16'h1113, 16'h1112, 16'h1111});
    step(0, 4'hF, {16'hEEEE, 16'hDDDD, 16'hCCCC, 16'hBBBB});
    repeat (5) step(0, '0, '0);

    // partial valid then a normal frame
    step(0, 4'b0101, {16'h5555, 16'h5555, 16'h5555, 16'h5555});
    step(0, '0, '0);
    step(0, 4'hF, {16'h2224, 16'h2223, 16'h2222, 16'h2221});
    repeat (5) step(0, '0, '0);

    // reset mid-frame
    step(0, 4'hF, {16'h3334, 16'h3333, 16'h3332, 16'h3331});
    step(0, '0, '0);
    step(1, '0, '0);
    chk("midreset_out_data", {16'b0, out_data}, 32'h0);
    step(0, '0, '0);
    step(0, '0, '0);
    step(0, 4'hF, {16'h4444, 16'h4443, 16'h4442, 16'h4441});
    repeat (5) step(0, '0, '0);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      int r;
      r  = $urandom_range(0, 99);
      rd = {$urandom(), $urandom()};
      if (r < 2)       step(1, '0, rd);
      else if (r < 40) step(0, 4'hF, rd);
      else if (r < 46) step(0, N'($urandom_range(1, 14)), rd);
      else             step(0, '0, rd);
    end
    repeat (8) step(0, '0, '0);
    chk("sb_drained", sb.size(), 32'h0);

    // single-neuron corner
    @(posedge clk); #1 rst1 = 1'b0;
    @(negedge clk);
    chk("n1_reset_valid", {31'b0, out_valid1}, 32'h0);
    @(posedge clk); #1;
    in_valid1 = 1'b1; in_data1 = 16'h7FFF;
    @(posedge clk); #1;
    in_data1 = 16'h1234;
    @(negedge clk);
    chk("n1_valid", {31'b0, out_valid1}, 32'h1);
    chk("n1_data", {16'b0, out_data1}, 32'h7FFF);
    chk("n1_done", {31'b0, done1}, 32'h1);
    @(posedge clk); #1;
    in_valid1 = 1'b0;
    @(negedge clk);
    chk("n1_b2b_valid", {31'b0, out_valid1}, 32'h1);
    chk("n1_b2b_data", {16'b0, out_data1}, 32'h1234);
    chk("n1_b2b_done", {31'b0, done1}, 32'h1);
    @(negedge clk);
    chk("n1_idle_valid", {31'b0, out_valid1}, 32'h0);
    chk("n1_idle_done", {31'b0, done1}, 32'h0);
    chk("n1_idle_busy", {31'b0, busy1}, 32'h0);
    chk("n1_overrun", {31'b0, overrun1}, 32'h0);

    mon_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/layer_output_serializer.md
# layer_output_serializer

Sits between two fully-connected layers. Captures the parallel outputs of all neurons of layer L when they complete, then streams them one word per cycle, neuron 0 first, onto the shared `myinput`/`myinputValid` bus that every neuron of layer L+1 consumes. There is no backpressure: downstream neurons accept one word per valid cycle.

## Interface
Parameters:
- `NUM_NEURONS`, default 30: number of neurons in the producing layer, and the number of words emitted per frame; must be ≥1.
- `DATA_WIDTH`, default 16: width of one neuron output word.

Ports:
- `clk`, input, 1: clock.
- `rst`, input, 1: synchronous reset, active-high.
- `in_data`, input, `NUM_NEURONS*DATA_WIDTH`: concatenated neuron outputs; neuron i occupies bits `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `in_valid`, input, `NUM_NEURONS`: per-neuron `outvalid` pulses.
- `out_data`, output, `DATA_WIDTH`: serial word to the next layer's `myinput`.
- `out_valid`, output, 1: qualifies `out_data`; drives the next layer's `myinputValid`.
- `busy`, output, 1: high while a frame is being emitted.
- `done`, output, 1: one-cycle pulse, coincident with the last word of a frame.
- `overrun`, output, 1: sticky; a capture arrived while busy and was dropped.
- `mismatch`, output, 1: sticky; `in_valid` was partially set in some cycle.

## Operation
- States: IDLE, SHIFT.
- Capture event: `&in_valid` is high in a cycle.
- IDLE + capture:
  - `out_data` <= word 0.
  - `out_valid` <= 1.
  - Buffer <= words 1..N-1.
  - `count` <= 1.
  - Go to SHIFT. If N=1, instead set `done` <= 1 and stay IDLE.
- SHIFT, each cycle:
  - `out_data` <= `buffer[0]`.
  - Buffer shifts down by one word.
  - `count` += 1.
  - `out_valid` <= 1.
  - When emitting word N-1: `done` <= 1 and go to IDLE.
- SHIFT + capture on the cycle word N-1 is emitted: the capture is accepted and the new frame starts next cycle with no gap. State stays SHIFT, `count` <= 1, and `out_data` <= new word 0 on the following edge sequencing as in IDLE.
- SHIFT + capture on any other cycle: the capture is dropped, `overrun` <= 1, and the current frame continues unaffected.
- `mismatch`: set when `|in_valid & ~&in_valid`; no capture occurs in that cycle.
- Sticky flags clear only on `rst`.
- `count` width: `$clog2(NUM_NEURONS+1)`. It never exceeds N-1 while in SHIFT.
- Data is passed through bit-exact; the block does no arithmetic on it.

## Timing
- Reset values:
  - `out_data` = 0, `out_valid` = 0, `busy` = 0, `done` = 0, `overrun` = 0, `mismatch` = 0.
  - State = IDLE, `count` = 0.
  - Buffer contents are don't-care.
- `rst` mid-frame: on the next edge everything returns to reset values and the remaining words are discarded. `rst` takes priority over a simultaneous capture.
- Latency: capture sampled at edge k, so `out_valid` is high on cycles k+1 through k+N contiguously and `done` is high on cycle k+N.
- `busy` = (state==SHIFT) | `out_valid`. It is high from cycle k+1 through k+N.
- When `out_valid` is low, `out_data` holds its last value. Downstream must qualify it with `out_valid`.
- Maximum throughput: one frame every N cycles.

## Structure
- Shared package `nn_pkg`:
  - State enum `ser_state_t` {IDLE, SHIFT}.
  - Function `cnt_width(n)` returning `$clog2(n+1)`.
  - Default `DATA_WIDTH` constant, shared with the neuron and weight memory.
- Single module; no sub-module is needed. The buffer is a `NUM_NEURONS-1`-word shift register, with a flat vector in, indexed internally.

## Test plan
All scenarios use N=4, DW=16.
- **Basic frame.** Reset, then `in_valid`=4'hF with words {0x0004,0x0003,0x0002,0x0001} (neuron3..0) at edge k. Required: `out_data` 0x0001, 0x0002, 0x0003, 0x0004 on cycles k+1..k+4; `out_valid` high exactly 4 cycles; `done` only at k+4.
- **Back-to-back frames.** Second capture {0x00D0,0x00C0,0x00B0,0x00A0} at edge k+3. Required: 8 contiguous valid words 1,2,3,4,A0,B0,C0,D0; no `overrun`; `done` at k+4 and k+8.
- **Overrun.** Second capture at edge k+1. Required: `overrun`=1 from k+2 and stays set; the first frame is unchanged; exactly 4 valid words in total.
- **Partial valid.** `in_valid`=4'b0101. Required: no `out_valid`; `mismatch`=1 sticky; a later full capture still serializes normally.
- **Reset mid-frame.** `rst` at edge k+2 after a capture at k. Required: `out_valid`=0 from k+3; `busy`=0; flags cleared; a new capture at k+5 emits all 4 words correctly.
- **N=1 corner.** Capture 0x7FFF. Required: a single valid cycle with 0x7FFF and `done` coincident with it.
